// File: rtl/ps2_rx_if.sv
// Read-side stream of the PS/2 receiver: FIFO head byte with valid/ready handshake.
// master = receiver (drives rd_valid/rd_data), slave = consumer (drives rd_ready).
interface ps2_rx_if;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       rd_ready;

  modport master (
    output rd_valid,
    output rd_data,
    input  rd_ready
  );

  modport slave (
    input  rd_valid,
    input  rd_data,
    output rd_ready
  );
endinterface

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver with first-word fall-through receive FIFO.
// Frame: start(0), 8 data bits LSB first, odd parity, stop(1), sampled on
// falling edges of the synchronized PS/2 clock. Frames that stall for
// TIMEOUT_CYC clk cycles are aborted.
// Optional feature: define PS2_RX_PARITY_CHECK_EN to reject frames whose
// parity bit does not give odd parity over the data byte; otherwise only the
// stop bit is checked.
module ps2_rx #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned TIMEOUT_CYC = 2000
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    ps2_clk,
  input  logic    ps2_data,
  ps2_rx_if.master rd,
  output logic    overflow,
  output logic    frame_err
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

  typedef enum logic {
    IDLE,
    RECV
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronization and falling-edge detection
  // ---------------------------------------------------------------------------
  logic [1:0] clk_sync;
  logic [1:0] dat_sync;
  logic       clk_prev;
  logic       ps2_edge;
  logic       sample;

  // Two-flop synchronizers plus one history flop; idle-high line state on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
      clk_prev <= clk_sync[1];
    end
  end

  assign ps2_edge = clk_prev & ~clk_sync[1];
  assign sample   = dat_sync[1];

  // ---------------------------------------------------------------------------
  // Frame assembly
  // ---------------------------------------------------------------------------
  state_t          state;
  logic [3:0]      bit_cnt;
  logic [9:0]      shreg;
  logic [TW-1:0]   to_cnt;

  logic            frame_done;
  logic            parity_ok;
  logic            frame_ok;
  logic            push_req;
  logic [7:0]      frame_byte;

  // On the completing edge the stop bit is still on the wire: shreg[8:1] holds
  // the data byte and shreg[9] the parity bit, so the frame is judged without
  // waiting for the final shift to land.
  assign frame_done = (state == RECV) && ps2_edge && (bit_cnt == 4'd10);
  assign frame_byte = shreg[8:1];

`ifdef PS2_RX_PARITY_CHECK_EN
  assign parity_ok = ^{frame_byte, shreg[9]};
`else
  assign parity_ok = 1'b1;
`endif

  assign frame_ok = sample & parity_ok;
  assign push_req = frame_done & frame_ok;

  // Receive FSM: start detection, bit shifting, completion check and timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      to_cnt    <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          to_cnt <= '0;
          if (ps2_edge) begin
            if (!sample) begin
              state   <= RECV;
              bit_cnt <= 4'd1;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        RECV: begin
          if (ps2_edge) begin
            to_cnt <= '0;
            shreg  <= {sample, shreg[9:1]};
            if (bit_cnt == 4'd10) begin
              state     <= IDLE;
              bit_cnt   <= '0;
              frame_err <= ~frame_ok;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else if (to_cnt == TW'(TIMEOUT_CYC - 1)) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            to_cnt    <= '0;
            frame_err <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          bit_cnt <= '0;
          to_cnt  <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FIFO (first-word fall-through, no empty bypass)
  // ---------------------------------------------------------------------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          not_empty;
  logic          full;
  logic          pop;
  logic          push_ok;

  assign not_empty = (count != '0);
  assign full      = (count == CW'(FIFO_DEPTH));
  assign pop       = not_empty & rd.rd_ready;
  assign push_ok   = push_req & (~full | pop);

  assign rd.rd_valid = not_empty;
  // Storage is not reset; masking keeps the head at zero whenever nothing is queued.
  assign rd.rd_data  = not_empty ? mem[rd_ptr] : '0;

  // Storage write for accepted frames.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= frame_byte;
    end
  end

  // Pointers, occupancy and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_req && !push_ok) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_rx.sv
// Self-checking bench for ps2_rx: drives PS/2 frames bit by bit, predicts
// delivered bytes in a scoreboard queue and compares them as they are popped.
module tb_ps2_rx;

  localparam int HALF  = 8;
  localparam int TO    = 100;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  logic overflow;
  logic frame_err;

  ps2_rx_if bus ();

  ps2_rx #(
    .FIFO_DEPTH (DEPTH),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .rd       (bus.master),
    .overflow (overflow),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int err_cnt = 0;
  int exp_err = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard monitor: every pop is compared against the oldest predicted byte.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_err) err_cnt++;
      if (bus.rd_valid && bus.rd_ready) begin
        if (exp_q.size() != 0) check("rd_data", bus.rd_data, exp_q.pop_front());
        else check("sb_nonempty", exp_q.size(), 1);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic odd_par(input logic [7:0] d);
    return ~^d;
  endfunction

  // Drive the first nedges bits of a frame; with sync_pop, rd_ready is pulsed
  // so the pop lands in the same clk cycle as the completing push.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input int nedges, input bit sync_pop);
    logic [10:0] f;
    f = {stop, par, d, 1'b0};
    for (int i = 0; i < nedges; i++) begin
      ps2_data = f[i];
      tick(HALF);
      ps2_clk = 1'b0;
      if (sync_pop && i == 10) begin
        tick(2);
        bus.rd_ready = 1'b1;
        tick(1);
        bus.rd_ready = 1'b0;
        tick(HALF - 3);
      end else begin
        tick(HALF);
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    tick(HALF);
  endtask

  task automatic good_frame(input logic [7:0] d);
    send_frame(d, odd_par(d), 1'b1, 11, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
  endtask

  initial begin
    bus.rd_ready = 1'b0;
    tick(3);
    check("rst_valid", bus.rd_valid, 0);
    check("rst_data", bus.rd_data, 0);
    check("rst_ovf", overflow, 0);
    check("rst_ferr", frame_err, 0);
    rst_n = 1'b1;
    tick(2);

    // Basic frame with consumer ready
    bus.rd_ready = 1'b1;
    exp_q.push_back(8'h1C);
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
    tick(6);
    check("1c_drained", exp_q.size(), 0);
    check("1c_err", err_cnt, exp_err);

    // Wrong parity
`ifdef PS2_RX_PARITY_CHECK_EN
    exp_err++;
`else
    exp_q.push_back(8'hF0);
`endif
    send_frame(8'hF0, 1'b0, 1'b1, 11, 1'b0);
    tick(6);
    check("f0_err", err_cnt, exp_err);
    check("f0_drained", exp_q.size(), 0);

    // Stop bit low
    exp_err++;
    send_frame(8'h3A, odd_par(8'h3A), 1'b0, 11, 1'b0);
    tick(6);
    check("stop_err", err_cnt, exp_err);
    check("stop_valid", bus.rd_valid, 0);

    // Falling edge with data high while idle
    exp_err++;
    ps2_data = 1'b1;
    tick(HALF);
    ps2_clk = 1'b0;
    tick(HALF);
    ps2_clk = 1'b1;
    tick(HALF);
    check("glitch_err", err_cnt, exp_err);

    // Timeout after 5 edges, then a clean frame
    exp_err++;
    send_frame(8'h77, 1'b0, 1'b1, 5, 1'b0);
    tick(TO + 2);
    check("to_err", err_cnt, exp_err);
    check("to_valid", bus.rd_valid, 0);
    exp_q.push_back(8'h55);
    good_frame(8'h55);
    tick(6);
    check("55_drained", exp_q.size(), 0);
    check("55_err", err_cnt, exp_err);

    // Full FIFO with same-cycle pop and push
    do_reset();
    bus.rd_ready = 1'b0;
    for (int v = 8'h11; v <= 8'h18; v++) begin
      exp_q.push_back(8'(v));
      good_frame(8'(v));
    end
    tick(4);
    check("full_ovf", overflow, 0);
    exp_q.push_back(8'h0A);
    send_frame(8'h0A, odd_par(8'h0A), 1'b1, 11, 1'b1);
    tick(4);
    check("sim_ovf", overflow, 0);
    check("sim_head", bus.rd_data, 8'h12);
    check("sim_pending", exp_q.size(), DEPTH);
    bus.rd_ready = 1'b1;
    tick(20);
    check("sim_drained", exp_q.size(), 0);
    check("sim_empty", bus.rd_valid, 0);

    // Overflow: nine frames into an eight-entry FIFO
    bus.rd_ready = 1'b0;
    for (int v = 1; v <= 9; v++) begin
      if (v <= DEPTH) exp_q.push_back(8'(v));
      good_frame(8'(v));
    end
    tick(4);
    check("ovf_set", overflow, 1);
    check("ovf_head", bus.rd_data, 8'h01);
    bus.rd_ready = 1'b1;
    tick(20);
    check("ovf_drained", exp_q.size(), 0);
    check("ovf_empty", bus.rd_valid, 0);
    check("ovf_sticky", overflow, 1);

    // Reset in the middle of a frame with bytes queued
    bus.rd_ready = 1'b0;
    exp_q.push_back(8'h31);
    good_frame(8'h31);
    exp_q.push_back(8'h32);
    good_frame(8'h32);
    tick(4);
    check("q2_valid", bus.rd_valid, 1);
    send_frame(8'hAA, odd_par(8'hAA), 1'b1, 7, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mrst_valid", bus.rd_valid, 0);
    check("mrst_ovf", overflow, 0);
    check("mrst_data", bus.rd_data, 0);
    exp_q.delete();
    tick(3);
    rst_n = 1'b1;
    tick(2);
    bus.rd_ready = 1'b1;
    exp_q.push_back(8'hAA);
    good_frame(8'hAA);
    tick(6);
    check("aa_drained", exp_q.size(), 0);
    check("aa_err", err_cnt, exp_err);
    check("aa_ovf", overflow, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
